// File: rtl/pong_pkg.sv
// Shared encodings and widths for the Pong match controller and its frame counter.
package pong_pkg;
    localparam int SCORE_W = 4;
    localparam int FCNT_W  = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SERVE     = 3'd1;
    localparam logic [2:0] ST_PLAY      = 3'd2;
    localparam logic [2:0] ST_POINT     = 3'd3;
    localparam logic [2:0] ST_GAME_OVER = 3'd4;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    // Score increment that sticks at the winning score.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? s : s + SCORE_W'(1);
    endfunction
endpackage

// File: rtl/frame_delay_counter.sv
// Counts frame ticks; done pulses combinationally on the tick that reaches target,
// so the owner can change state on that very edge.
module frame_delay_counter
    import pong_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              frame_tick,
    input  logic [FCNT_W-1:0] target,
    output logic              done
);
    logic [FCNT_W-1:0] cnt_q, cnt_d;

    // Must not depend on clear: clear is derived from the transition done causes.
    assign done = frame_tick && (cnt_q == target - FCNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (frame_tick)
            cnt_d = cnt_q + FCNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: game FSM, scores, serve direction, winner and start-button edge detect.
// Outputs are registered from next-state so they track `state` with no extra lag.
module pong_match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               entity_reset,
    output logic               play_enable,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner,
    output logic [2:0]         state
);
    localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);
    localparam logic [FCNT_W-1:0]  SERVE_T = FCNT_W'(SERVE_FRAMES);
    localparam logic [FCNT_W-1:0]  POINT_T = FCNT_W'(POINT_FRAMES);

    logic               start_q, start_prev_q;
    logic [2:0]         state_q, state_d;
    logic               serve_q, serve_d;
    logic [SCORE_W-1:0] sl_q, sl_d, sr_q, sr_d;
    logic [1:0]         win_q, win_d;
    logic               ent_q, play_q;
    logic               press, cnt_tick, cnt_clear, cnt_done;
    logic [FCNT_W-1:0]  cnt_target;

    assign press      = start_prev_q & ~start_q;
    assign cnt_tick   = frame_tick & ((state_q == ST_SERVE) | (state_q == ST_POINT));
    assign cnt_target = (state_q == ST_SERVE) ? SERVE_T : POINT_T;
    assign cnt_clear  = (state_d != state_q);

    frame_delay_counter u_delay (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .frame_tick (cnt_tick),
        .target     (cnt_target),
        .done       (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        serve_d = serve_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (press) begin
                    sl_d    = '0;
                    sr_d    = '0;
                    win_d   = WIN_NONE;
                    serve_d = 1'b1;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: if (cnt_done) state_d = ST_PLAY;
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    state_d = ST_POINT;
                end else if (miss_left) begin
                    sr_d    = sat_inc(sr_q, WIN_S);
                    serve_d = 1'b0;
                    state_d = ST_POINT;
                end else if (miss_right) begin
                    sl_d    = sat_inc(sl_q, WIN_S);
                    serve_d = 1'b1;
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (cnt_done) begin
                    if (sl_q == WIN_S) begin
                        win_d   = WIN_LEFT;
                        state_d = ST_GAME_OVER;
                    end else if (sr_q == WIN_S) begin
                        win_d   = WIN_RIGHT;
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            start_q      <= 1'b1;
            start_prev_q <= 1'b1;
            state_q      <= ST_IDLE;
            serve_q      <= 1'b1;
            sl_q         <= '0;
            sr_q         <= '0;
            win_q        <= WIN_NONE;
            ent_q        <= 1'b0;
            play_q       <= 1'b0;
        end else begin
            start_q      <= start_btn;
            start_prev_q <= start_q;
            state_q      <= state_d;
            serve_q      <= serve_d;
            sl_q         <= sl_d;
            sr_q         <= sr_d;
            win_q        <= win_d;
            ent_q        <= (state_d == ST_SERVE) | (state_d == ST_PLAY);
            play_q       <= (state_d == ST_PLAY);
        end
    end

    assign entity_reset = ent_q;
    assign play_enable  = play_q;
    assign serve_dir    = serve_q;
    assign score_left   = sl_q;
    assign score_right  = sr_q;
    assign winner       = win_q;
    assign state        = state_q;
endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: table of rally outcomes plus hand sequences for
// press timing, held button, stray misses and reset mid-POINT.
module tb_pong_match_controller;
    import pong_pkg::*;

    logic       clock = 1'b0, reset = 1'b0, frame_tick = 1'b0, start_btn = 1'b1;
    logic       miss_left = 1'b0, miss_right = 1'b0;
    logic       entity_reset, play_enable, serve_dir;
    logic [3:0] score_left, score_right;
    logic [1:0] winner;
    logic [2:0] state;

    pong_match_controller dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .miss_left(miss_left), .miss_right(miss_right), .entity_reset(entity_reset),
        .play_enable(play_enable), .serve_dir(serve_dir), .score_left(score_left),
        .score_right(score_right), .winner(winner), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       er, pe, sd;
        logic [3:0] sl, sr;
        logic [1:0] win;
    } outs_t;

    typedef struct {
        logic       ml, mr;
        logic [3:0] sl, sr;
        logic       sd;
        logic [2:0] exit_st;
        logic [1:0] win;
    } vec_t;

    outs_t exp_q[$];
    string nm_q[$];
    int    n_cmp = 0, n_bad = 0;

    function automatic outs_t mk(logic [2:0] st, logic er, logic pe, logic sd,
                                 logic [3:0] sl, logic [3:0] sr, logic [1:0] w);
        outs_t o;
        o = '{st: st, er: er, pe: pe, sd: sd, sl: sl, sr: sr, win: w};
        return o;
    endfunction

    task automatic pop_cmp();
        outs_t e, a;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        a  = {state, entity_reset, play_enable, serve_dir, score_left, score_right, winner};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got st=%0d er=%b pe=%b sd=%b sl=%0d sr=%0d win=%b, expected st=%0d er=%b pe=%b sd=%b sl=%0d sr=%0d win=%b",
                     nm, a.st, a.er, a.pe, a.sd, a.sl, a.sr, a.win,
                     e.st, e.er, e.pe, e.sd, e.sl, e.sr, e.win);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic drive(input logic ft, input logic ml, input logic mr,
                         input string nm, input outs_t e);
        frame_tick = ft; miss_left = ml; miss_right = mr;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clock); #1;
        frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        pop_cmp();
    endtask

    task automatic cyc(input logic ft, input logic ml, input logic mr);
        frame_tick = ft; miss_left = ml; miss_right = mr;
        @(posedge clock); #1;
        frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    endtask

    // n frame ticks with an idle gap every 16 so ticks, not cycles, are counted
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i % 16 == 15) cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic play_point(input logic ml, input logic mr, input int point_ticks);
        ticks(60);
        cyc(1'b0, ml, mr);
        ticks(point_ticks);
    endtask

    task automatic cmp_int(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    initial begin
        vec_t       tbl[8];
        outs_t      rst_o, e;
        logic [3:0] cur_sl, cur_sr;
        logic       cur_sd;
        int         n_tr;
        logic [2:0] prev_st;

        tbl[0] = '{1'b1, 1'b0, 4'd0, 4'd1, 1'b0, ST_SERVE,     WIN_NONE};
        tbl[1] = '{1'b1, 1'b1, 4'd0, 4'd1, 1'b0, ST_SERVE,     WIN_NONE};
        tbl[2] = '{1'b0, 1'b1, 4'd1, 4'd1, 1'b1, ST_SERVE,     WIN_NONE};
        tbl[3] = '{1'b0, 1'b1, 4'd2, 4'd1, 1'b1, ST_SERVE,     WIN_NONE};
        tbl[4] = '{1'b1, 1'b0, 4'd2, 4'd2, 1'b0, ST_SERVE,     WIN_NONE};
        tbl[5] = '{1'b0, 1'b1, 4'd3, 4'd2, 1'b1, ST_SERVE,     WIN_NONE};
        tbl[6] = '{1'b0, 1'b1, 4'd4, 4'd2, 1'b1, ST_SERVE,     WIN_NONE};
        tbl[7] = '{1'b0, 1'b1, 4'd5, 4'd2, 1'b1, ST_GAME_OVER, WIN_LEFT};

        rst_o = mk(ST_IDLE, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, WIN_NONE);

        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, "reset_state", rst_o);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, "idle_no_press", rst_o);

        start_btn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, "press_sync", rst_o);
        drive(1'b0, 1'b0, 1'b0, "press_serve", mk(ST_SERVE, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, WIN_NONE));
        start_btn = 1'b1;

        cur_sl = 4'd0; cur_sr = 4'd0; cur_sd = 1'b1;
        for (int v = 0; v < 8; v++) begin
            e = mk(ST_SERVE, 1'b1, 1'b0, cur_sd, cur_sl, cur_sr, WIN_NONE);
            drive(1'b0, 1'b1, 1'b0, "serve_stray_miss", e);
            ticks(58);
            drive(1'b1, 1'b0, 1'b0, "serve_tick59", e);
            drive(1'b1, 1'b0, 1'b0, "serve_to_play", mk(ST_PLAY, 1'b1, 1'b1, cur_sd, cur_sl, cur_sr, WIN_NONE));
            cur_sl = tbl[v].sl; cur_sr = tbl[v].sr; cur_sd = tbl[v].sd;
            e = mk(ST_POINT, 1'b0, 1'b0, cur_sd, cur_sl, cur_sr, WIN_NONE);
            drive(1'b0, tbl[v].ml, tbl[v].mr, "play_miss", e);
            drive(1'b0, 1'b0, 1'b1, "point_stray_miss", e);
            ticks(88);
            drive(1'b1, 1'b0, 1'b0, "point_tick89", e);
            if (tbl[v].exit_st == ST_SERVE)
                e = mk(ST_SERVE, 1'b1, 1'b0, cur_sd, cur_sl, cur_sr, WIN_NONE);
            else
                e = mk(tbl[v].exit_st, 1'b0, 1'b0, cur_sd, cur_sl, cur_sr, tbl[v].win);
            drive(1'b1, 1'b0, 1'b0, "point_exit", e);
        end

        e = mk(ST_GAME_OVER, 1'b0, 1'b0, 1'b1, 4'd5, 4'd2, WIN_LEFT);
        drive(1'b0, 1'b1, 1'b1, "gameover_stray_miss", e);
        drive(1'b1, 1'b0, 1'b0, "gameover_hold", e);
        start_btn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, "gameover_press_sync", e);
        drive(1'b0, 1'b0, 1'b0, "gameover_restart", mk(ST_SERVE, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, WIN_NONE));
        start_btn = 1'b1;

        play_point(1'b0, 1'b1, 90);
        play_point(1'b0, 1'b1, 90);
        play_point(1'b0, 1'b1, 90);
        play_point(1'b1, 1'b0, 90);
        play_point(1'b1, 1'b0, 45);
        drive(1'b0, 1'b0, 1'b0, "mid_point_3_2", mk(ST_POINT, 1'b0, 1'b0, 1'b0, 4'd3, 4'd2, WIN_NONE));
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, "reset_mid_point", rst_o);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, "idle_after_reset", rst_o);

        start_btn = 1'b0;
        n_tr = 0;
        prev_st = state;
        for (int i = 0; i < 500; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (prev_st == ST_IDLE && state == ST_SERVE) n_tr++;
            prev_st = state;
        end
        cmp_int("held_button_presses", n_tr, 1);
        e = mk(ST_SERVE, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, WIN_NONE);
        drive(1'b0, 1'b1, 1'b0, "held_serve_miss_left", e);
        drive(1'b0, 1'b0, 1'b1, "held_serve_miss_right", e);
        start_btn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
